// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver.
//   state_t / ST_*   : receiver FSM state encoding (2 bits)
//   UART_DATA_BITS   : data bits per frame (8N1)
package uart_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_START = 2'd1;
    localparam state_t ST_DATA  = 2'd2;
    localparam state_t ST_STOP  = 2'd3;

    localparam int UART_DATA_BITS = 8;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with show-ahead read.
//   clk, rst_n    : clock, asynchronous active-low reset
//   push, push_data : write request and data
//   pop           : read request; ignored when empty
//   rd_data       : current head (zero when empty)
//   empty         : no entries stored
//   count         : current occupancy
//   count_next    : occupancy after this cycle's accepted push/pop
//   overflow      : push refused this cycle because the FIFO was full
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic [$clog2(DEPTH):0]   count_next,
    output logic                     overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr_reg;
    logic [PW-1:0]    rd_ptr_reg;
    logic             full;
    logic             do_push;
    logic             do_pop;

    // Pointers carry an extra wrap bit so full and empty are distinguishable.
    assign empty = (wr_ptr_reg == rd_ptr_reg);
    assign full  = ((wr_ptr_reg ^ rd_ptr_reg) == PW'(DEPTH));

    // A pop in the same cycle frees the slot, so a push into a full FIFO
    // is still accepted when it coincides with a pop.
    assign do_pop   = pop & ~empty;
    assign do_push  = push & (~full | do_pop);
    assign overflow = push & full & ~do_pop;

    assign count      = wr_ptr_reg - rd_ptr_reg;
    assign count_next = count + PW'(do_push) - PW'(do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_reg[AW-1:0]] <= push_data;
    end

    // Storage is not reset, so the head is masked to zero while empty.
    assign rd_data = empty ? '0 : mem[rd_ptr_reg[AW-1:0]];

endmodule

// File: rtl/uart_rx_intc.sv
// 8N1 UART receiver with RX FIFO and level interrupt for the core.
//   CLK      : system clock
//   RESET    : asynchronous active-low reset
//   RX       : asynchronous serial input, idle high
//   RD_EN    : pop one FIFO entry
//   ERR_CLR  : clear sticky error flags
//   RD_DATA  : FIFO head (show-ahead), valid with RD_VALID
//   RD_VALID : FIFO non-empty
//   COUNT    : FIFO occupancy
//   OVR_ERR  : sticky, byte dropped on full FIFO
//   FRM_ERR  : sticky, stop bit sampled low
//   UART_INT : registered interrupt request
module uart_rx_intc
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT  = 868,
    parameter int FIFO_DEPTH    = 16,
    parameter int INT_THRESHOLD = 1
) (
    input  logic                          CLK,
    input  logic                          RESET,
    input  logic                          RX,
    input  logic                          RD_EN,
    input  logic                          ERR_CLR,
    output logic [UART_DATA_BITS-1:0]     RD_DATA,
    output logic                          RD_VALID,
    output logic [$clog2(FIFO_DEPTH):0]   COUNT,
    output logic                          OVR_ERR,
    output logic                          FRM_ERR,
    output logic                          UART_INT
);

    localparam int CW  = $clog2(FIFO_DEPTH) + 1;
    localparam int CCW = $clog2(CLKS_PER_BIT);
    localparam int BCW = $clog2(UART_DATA_BITS);

    logic                      rx_meta_reg, rx_sync_reg, rx_prev_reg;
    logic                      rx_fall;
    state_t                    state_reg, state_next;
    logic [CCW-1:0]            clk_cnt_reg;
    logic [BCW-1:0]            bit_cnt_reg;
    logic [UART_DATA_BITS-1:0] shift_reg;
    logic                      half_tick, bit_tick, last_bit;
    logic                      cnt_clr, bit_shift, push_req, frm_set;
    logic                      fifo_empty, ovr_set;
    logic [CW-1:0]             count_next;
    logic                      ovr_reg, ovr_next, frm_reg, frm_next, int_reg, int_next;

    // Two-flop synchroniser plus one history flop for edge detection.
    // Resetting to the idle level avoids a false start on reset release.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            rx_meta_reg <= 1'b1;
            rx_sync_reg <= 1'b1;
            rx_prev_reg <= 1'b1;
        end else begin
            rx_meta_reg <= RX;
            rx_sync_reg <= rx_meta_reg;
            rx_prev_reg <= rx_sync_reg;
        end
    end

    assign rx_fall   = rx_prev_reg & ~rx_sync_reg;
    assign half_tick = (clk_cnt_reg == CCW'(CLKS_PER_BIT / 2 - 1));
    assign bit_tick  = (clk_cnt_reg == CCW'(CLKS_PER_BIT - 1));
    assign last_bit  = (bit_cnt_reg == BCW'(UART_DATA_BITS - 1));

    // FSM: state register
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) state_reg <= ST_IDLE;
        else        state_reg <= state_next;
    end

    // FSM: next state
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (rx_fall) state_next = ST_START;
            // A start bit that is high again at mid-bit was a glitch.
            ST_START: if (half_tick) state_next = rx_sync_reg ? ST_IDLE : ST_DATA;
            ST_DATA:  if (bit_tick && last_bit) state_next = ST_STOP;
            ST_STOP:  if (bit_tick) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        cnt_clr   = 1'b0;
        bit_shift = 1'b0;
        push_req  = 1'b0;
        frm_set   = 1'b0;
        case (state_reg)
            ST_IDLE:  cnt_clr = 1'b1;
            ST_START: cnt_clr = half_tick;
            ST_DATA: begin
                cnt_clr   = bit_tick;
                bit_shift = bit_tick;
            end
            ST_STOP: begin
                cnt_clr  = bit_tick;
                push_req = bit_tick & rx_sync_reg;
                frm_set  = bit_tick & ~rx_sync_reg;
            end
            default: cnt_clr = 1'b1;
        endcase
    end

    // Bit timing and deserialisation, LSB first.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            clk_cnt_reg <= '0;
            bit_cnt_reg <= '0;
            shift_reg   <= '0;
        end else begin
            clk_cnt_reg <= cnt_clr ? '0 : clk_cnt_reg + CCW'(1);
            if (state_reg == ST_IDLE) begin
                bit_cnt_reg <= '0;
            end else if (bit_shift) begin
                shift_reg[bit_cnt_reg] <= rx_sync_reg;
                bit_cnt_reg            <= bit_cnt_reg + BCW'(1);
            end
        end
    end

    sync_fifo #(
        .WIDTH (UART_DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (CLK),
        .rst_n      (RESET),
        .push       (push_req),
        .push_data  (shift_reg),
        .pop        (RD_EN),
        .rd_data    (RD_DATA),
        .empty      (fifo_empty),
        .count      (COUNT),
        .count_next (count_next),
        .overflow   (ovr_set)
    );

    assign RD_VALID = ~fifo_empty;

    // Error events override a simultaneous clear.
    always_comb begin
        ovr_next = (ovr_reg & ~ERR_CLR) | ovr_set;
        frm_next = (frm_reg & ~ERR_CLR) | frm_set;
        int_next = (count_next >= CW'(INT_THRESHOLD)) | ovr_next | frm_next;
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            ovr_reg <= 1'b0;
            frm_reg <= 1'b0;
            int_reg <= 1'b0;
        end else begin
            ovr_reg <= ovr_next;
            frm_reg <= frm_next;
            int_reg <= int_next;
        end
    end

    assign OVR_ERR  = ovr_reg;
    assign FRM_ERR  = frm_reg;
    assign UART_INT = int_reg;

endmodule

// File: tb/tb_uart_rx_intc.sv
module tb_uart_rx_intc;

    localparam int CPB   = 16;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic       rd_en = 1'b0;
    logic       err_clr = 1'b0;

    logic [7:0] rd_data, rd_data3;
    logic       rd_valid, rd_valid3;
    logic [2:0] count, count3;
    logic       ovr_err, ovr_err3, frm_err, frm_err3, uart_int, uart_int3;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: byte queue plus sticky flags, updated per transaction.
    logic [7:0] q[$];
    bit         m_ovr = 0;
    bit         m_frm = 0;

    always #5 clk = ~clk;

    uart_rx_intc #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .INT_THRESHOLD(1)) dut (
        .CLK(clk), .RESET(rst_n), .RX(rx), .RD_EN(rd_en), .ERR_CLR(err_clr),
        .RD_DATA(rd_data), .RD_VALID(rd_valid), .COUNT(count),
        .OVR_ERR(ovr_err), .FRM_ERR(frm_err), .UART_INT(uart_int)
    );

    uart_rx_intc #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .INT_THRESHOLD(3)) dut3 (
        .CLK(clk), .RESET(rst_n), .RX(rx), .RD_EN(rd_en), .ERR_CLR(err_clr),
        .RD_DATA(rd_data3), .RD_VALID(rd_valid3), .COUNT(count3),
        .OVR_ERR(ovr_err3), .FRM_ERR(frm_err3), .UART_INT(uart_int3)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic void m_frame(input logic [7:0] b, input bit ok);
        if (!ok)                  m_frm = 1;
        else if (q.size() < DEPTH) q.push_back(b);
        else                      m_ovr = 1;
    endfunction

    function automatic void m_pop();
        if (q.size() != 0) void'(q.pop_front());
    endfunction

    function automatic void m_reset();
        q.delete();
        m_ovr = 0;
        m_frm = 0;
    endfunction

    task automatic check_all(input string tag);
        chk({tag, ":count"}, 32'(count), 32'(q.size()));
        chk({tag, ":valid"}, 32'(rd_valid), 32'(q.size() != 0));
        if (q.size() != 0) chk({tag, ":data"}, 32'(rd_data), 32'(q[0]));
        chk({tag, ":ovr"}, 32'(ovr_err), 32'(m_ovr));
        chk({tag, ":frm"}, 32'(frm_err), 32'(m_frm));
        chk({tag, ":int"}, 32'(uart_int), 32'((q.size() >= 1) | m_ovr | m_frm));
        chk({tag, ":count3"}, 32'(count3), 32'(q.size()));
        chk({tag, ":int3"}, 32'(uart_int3), 32'((q.size() >= 3) | m_ovr | m_frm));
        $display("txn %s: count=%0d head=%02h ovr=%0d frm=%0d int=%0d int3=%0d",
                 tag, count, rd_data, ovr_err, frm_err, uart_int, uart_int3);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, ":data"}, 32'(rd_data), 0);
        chk({tag, ":valid"}, 32'(rd_valid), 0);
        chk({tag, ":count"}, 32'(count), 0);
        chk({tag, ":ovr"}, 32'(ovr_err), 0);
        chk({tag, ":frm"}, 32'(frm_err), 0);
        chk({tag, ":int"}, 32'(uart_int), 0);
        chk({tag, ":valid3"}, 32'(rd_valid3), 0);
        chk({tag, ":int3"}, 32'(uart_int3), 0);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drives one frame starting just after a clock edge (E0). The stop bit
    // is sampled at edge E155, so the byte becomes visible just after it.
    task automatic send_frame(input logic [7:0] b, input bit stop_ok, input bit chk_lat);
        @(posedge clk); #1 rx = 1'b0;
        for (int i = 0; i < 8; i++) begin
            repeat (CPB) @(posedge clk);
            #1 rx = b[i];
        end
        repeat (CPB) @(posedge clk);
        #1 rx = stop_ok;
        repeat (10) @(posedge clk);
        #1;
        if (chk_lat) chk("lat_before", 32'(rd_valid), 0);
        @(posedge clk); #1;
        if (chk_lat) chk("lat_after", 32'(rd_valid), 1);
        repeat (5) @(posedge clk);
        #1 rx = 1'b1;
        tick(4);
    endtask

    task automatic pop_one();
        rd_en = 1'b1;
        @(posedge clk); #1 rd_en = 1'b0;
        m_pop();
    endtask

    task automatic clear_err();
        err_clr = 1'b1;
        @(posedge clk); #1 err_clr = 1'b0;
        m_ovr = 0;
        m_frm = 0;
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] b;
        bit         ok;
        int         r;

        tick(3);
        chk_reset("por");
        rst_n = 1'b1;
        tick(3);
        check_all("idle");

        // Single frame, latency and pop
        send_frame(8'hA5, 1, 1);
        m_frame(8'hA5, 1);
        check_all("a5");
        pop_one();
        check_all("a5_pop");
        tick(1);
        check_all("a5_pop2");

        // Short start glitch
        @(posedge clk); #1 rx = 1'b0;
        repeat (5) @(posedge clk);
        #1 rx = 1'b1;
        tick(40);
        check_all("glitch");

        // Overrun
        for (int i = 1; i <= 5; i++) begin
            send_frame(8'(i), 1, 0);
            m_frame(8'(i), 1);
        end
        check_all("ovr");
        for (int i = 0; i < 4; i++) begin
            check_all("drain");
            pop_one();
        end
        clear_err();
        check_all("ovr_clr");

        // Framing error
        send_frame(8'h3C, 0, 0);
        m_frame(8'h3C, 0);
        check_all("frm");
        clear_err();
        check_all("frm_clr");

        // Push into full FIFO coinciding with a pop
        for (int i = 0; i < 4; i++) begin
            send_frame(8'h60 + 8'(i), 1, 0);
            m_frame(8'h60 + 8'(i), 1);
        end
        check_all("full");
        fork
            send_frame(8'h77, 1, 0);
            begin
                @(posedge clk); #1;
                repeat (154) @(posedge clk);
                #1 rd_en = 1'b1;
                @(posedge clk); #1 rd_en = 1'b0;
            end
        join
        m_pop();
        m_frame(8'h77, 1);
        check_all("push_pop");
        for (int i = 0; i < 4; i++) begin
            check_all("drain77");
            pop_one();
        end
        check_all("empty77");

        // Error event in the same cycle as ERR_CLR
        fork
            send_frame(8'h81, 0, 0);
            begin
                @(posedge clk); #1;
                repeat (154) @(posedge clk);
                #1 err_clr = 1'b1;
                @(posedge clk); #1 err_clr = 1'b0;
            end
        join
        m_ovr = 0;
        m_frm = 0;
        m_frame(8'h81, 0);
        check_all("set_wins");
        clear_err();

        // Randomized traffic
        for (int n = 0; n < 40; n++) begin
            r = $urandom_range(0, 9);
            if (r <= 5) begin
                b  = 8'($urandom);
                ok = ($urandom_range(0, 7) != 0);
                send_frame(b, ok, 0);
                m_frame(b, ok);
                check_all(ok ? "rnd_frame" : "rnd_badstop");
            end else if (r <= 8) begin
                pop_one();
                check_all("rnd_pop");
            end else begin
                clear_err();
                check_all("rnd_clr");
            end
        end

        // Reset in the middle of a frame
        send_frame(8'h11, 1, 0);
        m_frame(8'h11, 1);
        send_frame(8'h22, 0, 0);
        m_frame(8'h22, 0);
        check_all("pre_rst");
        fork
            send_frame(8'hC3, 1, 0);
            begin
                @(posedge clk); #1;
                repeat (5 * CPB + 8) @(posedge clk);
                #3 rst_n = 1'b0;
                #1 chk_reset("mid_rst");
            end
        join
        m_reset();
        tick(2);
        rst_n = 1'b1;
        tick(20);
        check_all("post_rst");
        send_frame(8'h5A, 1, 0);
        m_frame(8'h5A, 1);
        check_all("5a");
        send_frame(8'h2B, 1, 0);
        m_frame(8'h2B, 1);
        check_all("thr2");
        send_frame(8'hE7, 1, 0);
        m_frame(8'hE7, 1);
        check_all("thr3");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
